// File: rtl/progmem_loader.sv
// UART boot loader: receives a framed, checksummed program image and writes it into
// program memory, holding the CPU in reset until the image is verified or the idle wait expires.
module progmem_loader #(
    parameter logic [31:0] PROG_BASE      = 32'h0010_0000,
    parameter int unsigned MAX_WORDS      = 8192,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        progmem_wen,
    output logic [31:0] progmem_waddr,
    output logic [31:0] progmem_wdata,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WW = $clog2(MAX_WORDS + 1);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StRun,
        StErr
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    byte_q, byte_d;
    logic [WW-1:0] word_idx_q, word_idx_d;
    logic [WW-1:0] count_q, count_d;
    logic [31:0]   shift_q, shift_d;
    logic [7:0]    csum_q, csum_d;
    logic          wen_q, wen_d;
    logic [31:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cpu_resetn_q, cpu_resetn_d;
    logic          done_q, done_d;
    logic          timed;
    logic          timeout_hit;

    assign timed       = (state_q == StIdle) || (state_q == StLen) ||
                         (state_q == StData) || (state_q == StCsum);
    // An arriving byte always wins over an expiring timer.
    assign timeout_hit = !rx_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        byte_d       = byte_q;
        word_idx_d   = word_idx_q;
        count_d      = count_q;
        shift_d      = shift_q;
        csum_d       = csum_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        done_d       = done_q;
        cpu_resetn_d = (state_q == StRun);

        if (timed && !rx_valid) begin
            timer_d = timer_q + TW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = StLen;
                        byte_d  = '0;
                        csum_d  = '0;
                    end
                end else if (timeout_hit) begin
                    state_d = StRun;
                end
            end
            StLen: begin
                if (rx_valid) begin
                    csum_d  = csum_q + rx_data;
                    shift_d = {rx_data, shift_q[31:8]};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if ((shift_d == 32'd0) || (shift_d > 32'(MAX_WORDS))) begin
                            state_d = StErr;
                        end else begin
                            state_d    = StData;
                            word_idx_d = '0;
                            count_d    = shift_d[WW-1:0];
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StData: begin
                if (rx_valid) begin
                    csum_d  = csum_q + rx_data;
                    shift_d = {rx_data, shift_q[31:8]};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        wen_d      = 1'b1;
                        waddr_d    = PROG_BASE + (32'(word_idx_q) << 2);
                        wdata_d    = shift_d;
                        word_idx_d = word_idx_q + WW'(1);
                        if (word_idx_q == count_q - WW'(1)) begin
                            state_d = StCsum;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StCsum: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StErr;
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            StErr: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = StLen;
                    byte_d  = '0;
                    csum_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            byte_q       <= '0;
            word_idx_q   <= '0;
            count_q      <= '0;
            shift_q      <= '0;
            csum_q       <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            cpu_resetn_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            byte_q       <= byte_d;
            word_idx_q   <= word_idx_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            cpu_resetn_q <= cpu_resetn_d;
            done_q       <= done_d;
        end
    end

    assign progmem_wen   = wen_q;
    assign progmem_waddr = waddr_q;
    assign progmem_wdata = wdata_q;
    assign cpu_resetn    = cpu_resetn_q;
    assign done          = done_q;
    assign busy          = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign error         = (state_q == StErr);

endmodule

// File: tb/tb_progmem_loader.sv
// Bench for progmem_loader: directed frames plus randomized images, with expected memory
// writes queued by the stimulus and consumed by an independent write monitor.
module tb_progmem_loader;

    localparam logic [31:0] PROG_BASE = 32'h0010_0000;
    localparam int unsigned MAX_W     = 16;
    localparam int unsigned TMO       = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        progmem_wen;
    logic [31:0] progmem_waddr;
    logic [31:0] progmem_wdata;
    logic        cpu_resetn;
    logic        busy;
    logic        done;
    logic        error;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] img[$];
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;

    progmem_loader #(
        .PROG_BASE      (PROG_BASE),
        .MAX_WORDS      (MAX_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .progmem_wen   (progmem_wen),
        .progmem_waddr (progmem_waddr),
        .progmem_wdata (progmem_wdata),
        .cpu_resetn    (cpu_resetn),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard; between strobes
    // the address/data must hold.
    always @(negedge clk) begin
        if (reset) begin
            last_addr <= 32'd0;
            last_data <= 32'd0;
        end else if (progmem_wen) begin
            if (exp_addr_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                         progmem_waddr, progmem_wdata);
            end else begin
                check("write_addr", progmem_waddr, exp_addr_q.pop_front());
                check("write_data", progmem_wdata, exp_data_q.pop_front());
            end
            last_addr <= progmem_waddr;
            last_data <= progmem_wdata;
        end else begin
            check("hold_addr", progmem_waddr, last_addr);
            check("hold_data", progmem_wdata, last_data);
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // gap idle cycles, then one cycle with the byte strobed
    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return TMO - 1;
        if ($urandom_range(0, 7) == 0) return TMO - 1;
        return int'($urandom_range(0, 4));
    endfunction

    task automatic check_status(input string tag, input logic b, input logic d,
                                input logic e, input logic c);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e});
        check({tag, "_cpu_resetn"}, {31'd0, cpu_resetn}, {31'd0, c});
    endtask

    // Sends a frame for the image in img; the model: valid length -> every word written at
    // PROG_BASE + 4*i; final outcome RUN+done if the checksum matches, ERR otherwise.
    task automatic send_image(input string tag, input logic [31:0] count,
                              input logic [7:0] csum_xor, input int mode);
        logic [7:0] cs;
        logic [7:0] b;
        logic [31:0] w;
        bit valid;
        cs = 8'd0;
        valid = (count != 0) && (count <= MAX_W);
        send(8'hA5, (mode == 1) ? TMO - 1 : int'($urandom_range(0, 3)));
        for (int k = 0; k < 4; k++) begin
            b = count[8*k +: 8];
            cs = cs + b;
            send(b, pick_gap(mode));
        end
        if (valid) begin
            for (int i = 0; i < int'(count); i++) begin
                w = img[i];
                exp_addr_q.push_back(PROG_BASE + 32'(4 * i));
                exp_data_q.push_back(w);
                for (int k = 0; k < 4; k++) begin
                    b = w[8*k +: 8];
                    cs = cs + b;
                    send(b, pick_gap(mode));
                end
            end
            send(cs ^ csum_xor, pick_gap(mode));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (valid && csum_xor == 8'd0) check_status(tag, 1'b0, 1'b1, 1'b0, 1'b1);
        else check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
        check({tag, "_pending_writes"}, exp_addr_q.size(), 32'd0);
        #1;
    endtask

    initial begin
        logic [31:0] cnt;
        logic [7:0]  cx;

        // Reset state
        do_reset();
        @(negedge clk);
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_waddr", progmem_waddr, 32'd0);
        check("reset_wdata", progmem_wdata, 32'd0);
        check("reset_wen", {31'd0, progmem_wen}, 32'd0);

        // Good load
        do_reset();
        img = '{32'h0000_0013, 32'h0000_006F};
        send_image("good", 32'd2, 8'h00, 0);

        // Bad checksum, then ERR ignores junk and A5 restarts
        do_reset();
        send_image("badcsum", 32'd2, 8'h01, 0);
        send(8'h11, 0);
        idle(3 * TMO);
        @(negedge clk);
        check("err_sticky", {31'd0, error}, 32'd1);
        #1;
        send(8'hA5, 0);
        @(negedge clk);
        check_status("resync", 1'b1, 1'b0, 1'b0, 1'b0);
        #1;

        // Idle timeout: cpu released on cycle TMO+1, later bytes ignored
        do_reset();
        repeat (TMO) @(posedge clk);
        @(negedge clk);
        check("idle_cpu_cycle16", {31'd0, cpu_resetn}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_status("idle_run", 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        send(8'hA5, 0);
        send(8'hA5, 0);
        @(negedge clk);
        check_status("run_ignores", 1'b0, 1'b0, 1'b0, 1'b1);
        #1;

        // Length boundaries
        do_reset();
        send_image("len0", 32'd0, 8'h00, 0);
        do_reset();
        send_image("len_over", 32'(MAX_W + 1), 8'h00, 0);
        do_reset();
        img = {};
        for (int i = 0; i < int'(MAX_W); i++) img.push_back($urandom);
        send_image("len_max", 32'(MAX_W), 8'h00, 0);

        // Timeout edge: a gap of TMO idle cycles mid-word errors
        do_reset();
        send(8'hA5, 0);
        send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'hDE, 0); send(8'hAD, 0);
        idle(TMO - 1);
        @(negedge clk);
        check("tmo_not_yet", {31'd0, error}, 32'd0);
        #1;
        idle(1);
        @(negedge clk);
        check_status("tmo_mid", 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        // Bytes landing in the expiry cycle are accepted throughout
        do_reset();
        img = '{32'hCAFE_F00D, 32'h1234_5678, 32'h0BAD_BEEF};
        send_image("tmo_edge", 32'd3, 8'h00, 1);

        // Reset mid-word
        do_reset();
        img = '{32'h8765_4321};
        exp_addr_q.push_back(PROG_BASE);
        exp_data_q.push_back(32'h8765_4321);
        send(8'hA5, 0);
        send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h21, 0); send(8'h43, 0); send(8'h65, 0); send(8'h87, 0);
        send(8'h55, 1); send(8'h66, 0);
        do_reset();
        @(negedge clk);
        check_status("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset_waddr", progmem_waddr, 32'd0);
        check("midreset_wdata", progmem_wdata, 32'd0);
        #1;
        idle(8);
        check("midreset_pending", exp_addr_q.size(), 32'd0);

        // Randomized images
        for (int t = 0; t < 20; t++) begin
            do_reset();
            if ($urandom_range(0, 3) == 0) send(8'h5A, int'($urandom_range(0, 2)));
            case ($urandom_range(0, 9))
                0:       cnt = 32'd0;
                1:       cnt = 32'($urandom_range(MAX_W + 1, 300));
                default: cnt = 32'($urandom_range(1, MAX_W));
            endcase
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            img = {};
            for (int i = 0; i < int'(MAX_W); i++) img.push_back($urandom);
            send_image("rand", cnt, cx, 2);
        end

        idle(4);
        check("final_pending", exp_addr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
